projectile_ctrl: RTL

PROJECTILE_CTRL -- requirements
Module: projectile_ctrl

---
 rtl/projectile_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/projectile_ctrl.sv
// projectile_ctrl: launches, moves and retires a single player projectile.
//
// Inputs fire_btn, clk_projectile and clk_cooldown are asynchronous to
// master_clk. Each one passes through a two-flop synchronizer plus a third
// delay flop, and a rising-edge event is taken from the last two stages.
// The divided clocks are used only as data and never clock any flop.
//
// A three-process FSM (IDLE / FLIGHT / COOLDOWN) sequences a shot:
//   IDLE     -> FLIGHT   : fire event; muzzle position loaded, shot_fired pulse
//   FLIGHT   -> COOLDOWN : hit, or a step tick that would move proj_y below 0
//   COOLDOWN -> IDLE     : cooldown counter already at zero
// The unused state code falls back to IDLE.
//
// Optional feature, macro PROJ_FIRE_QUEUE_EN:
//   defined   - a fire event seen during FLIGHT or COOLDOWN is remembered in
//               a one-deep pending flag, and the shot launches on the edge
//               after the FSM returns to IDLE.
//   undefined - fire events outside IDLE are dropped.
//
// Handshake: there is no backpressure. shot_fired is a one-cycle strobe,
// qualified by nothing, that marks the cycle in which proj_x/proj_y first
// show the freshly loaded muzzle position. fire_ready is a level that is
// high exactly while the FSM sits in IDLE.
//
// state_dbg exposes the FSM state for debug and checkers.

module projectile_ctrl #(
    parameter logic [9:0] SHIP_Y         = 10'd440,
    parameter logic [9:0] PROJ_STEP      = 10'd4,
    parameter logic [9:0] X_OFFSET       = 10'd16,
    parameter logic [3:0] COOLDOWN_TICKS = 4'd3
) (
    input  logic       master_clk,
    input  logic       RESET_debounced,
    input  logic       fire_btn,
    input  logic [9:0] ship_x,
    input  logic       clk_projectile,
    input  logic       clk_cooldown,
    input  logic       hit,
    output logic       proj_active,
    output logic [9:0] proj_x,
    output logic [9:0] proj_y,
    output logic       fire_ready,
    output logic       shot_fired,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FLIGHT   = 2'b01,
        COOLDOWN = 2'b10
    } state_t;

    state_t     state;
    state_t     next_state;

    // Synchronizer chains: [0] first sync flop, [1] second sync flop,
    // [2] delay flop used for edge detection.
    logic [2:0] fire_sync;
    logic [2:0] step_sync;
    logic [2:0] cool_sync;

    logic       fire_ev;
    logic       step_ev;
    logic       cool_ev;

    logic [3:0] cool_cnt;
    logic       launch;
    logic       flight_end;
    logic       pending;

    // Fire button chain resets high so a button held through reset produces no edge.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            fire_sync <= 3'b111;
        end else begin
            fire_sync <= {fire_sync[1:0], fire_btn};
        end
    end

    // Step-clock chain; resets low.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            step_sync <= 3'b000;
        end else begin
            step_sync <= {step_sync[1:0], clk_projectile};
        end
    end

    // Cooldown-clock chain; resets low.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            cool_sync <= 3'b000;
        end else begin
            cool_sync <= {cool_sync[1:0], clk_cooldown};
        end
    end

    // One-cycle rising-edge events from the synchronized second and third stages.
    always_comb begin
        fire_ev = fire_sync[1] & ~fire_sync[2];
        step_ev = step_sync[1] & ~step_sync[2];
        cool_ev = cool_sync[1] & ~cool_sync[2];
    end

`ifdef PROJ_FIRE_QUEUE_EN
    // Remember one fire request made while busy; consumed by the next launch.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            pending <= 1'b0;
        end else if (launch) begin
            pending <= 1'b0;
        end else if (fire_ev && (state == FLIGHT || state == COOLDOWN)) begin
            pending <= 1'b1;
        end
    end

    // A launch happens in IDLE on a fresh fire event or a remembered one.
    always_comb begin
        launch = (state == IDLE) && (fire_ev || pending);
    end
`else
    // No request memory: the flag is tied low and only fresh events in IDLE launch.
    always_comb begin
        pending = 1'b0;
        launch  = (state == IDLE) && fire_ev && !pending;
    end
`endif

    // Flight ends on a hit, or on a step tick with too little height left to move.
    always_comb begin
        flight_end = (state == FLIGHT) &&
                     (hit || (step_ev && (proj_y < PROJ_STEP)));
    end

    // FSM state register.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; the unused code recovers to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                next_state = launch ? FLIGHT : IDLE;
            end
            FLIGHT: begin
                next_state = flight_end ? COOLDOWN : FLIGHT;
            end
            COOLDOWN: begin
                next_state = (cool_cnt == 4'd0) ? IDLE : COOLDOWN;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        fire_ready  = (state == IDLE);
        proj_active = (state == FLIGHT);
        state_dbg   = state;
    end

    // Projectile position: loaded at launch, stepped upward in flight, held otherwise.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            proj_x <= 10'd0;
            proj_y <= 10'd0;
        end else if (launch) begin
            proj_x <= ship_x + X_OFFSET;
            proj_y <= SHIP_Y;
        end else if (state == FLIGHT && !hit && step_ev && (proj_y >= PROJ_STEP)) begin
            proj_y <= proj_y - PROJ_STEP;
        end
    end

    // Launch strobe, aligned with the first cycle the new position is visible.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            shot_fired <= 1'b0;
        end else begin
            shot_fired <= launch;
        end
    end

    // Cooldown counter: loaded when the flight ends, decremented on cooldown ticks.
    always_ff @(posedge master_clk) begin
        if (RESET_debounced) begin
            cool_cnt <= 4'd0;
        end else if (flight_end) begin
            cool_cnt <= COOLDOWN_TICKS;
        end else if (state == COOLDOWN && cool_cnt != 4'd0 && cool_ev) begin
            cool_cnt <= cool_cnt - 4'd1;
        end
    end

endmodule
